// File: rtl/seq_1001_pkg.sv
// Shared constants and state type for the 1001 sync-sequence link
// (transmitter, detector and deframer all import this package).
package seq_1001_pkg;

  localparam logic [3:0] SYNC_PATTERN  = 4'b1001;
  localparam int         SYNC_LEN      = 4;
  localparam logic [2:0] STUFF_TRIGGER = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    STUFF
  } state_t;

endpackage

// File: rtl/seq_tx_1001.sv
// Serial frame transmitter: sends preamble 1001 then the payload MSB first,
// inserting a 0 after every 100 so the sync pattern never appears in payload.
module seq_tx_1001
  import seq_1001_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);
  localparam logic [1:0]       PRE_LAST = 2'(SYNC_LEN - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
  logic [1:0]        pre_cnt, pre_nxt;
  logic [2:0]        hist, hist_nxt;
  logic              out_nxt, valid_nxt, done_nxt;
  logic              emit_payload;
  logic [2:0]        hist_base;

  // Registered outputs are computed one edge ahead: state names what the
  // serial line carries in the current cycle.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    cnt_nxt      = bit_cnt;
    pre_nxt      = pre_cnt;
    hist_nxt     = hist;
    out_nxt      = 1'b0;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    emit_payload = 1'b0;
    hist_base    = hist;

    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = PRE;
          shreg_nxt = in_data;
          cnt_nxt   = '0;
          pre_nxt   = 2'd0;
          out_nxt   = SYNC_PATTERN[3];
          valid_nxt = 1'b1;
        end
      end
      PRE: begin
        if (pre_cnt == PRE_LAST) begin
          // History starts from the tail of the preamble (001).
          emit_payload = 1'b1;
          hist_base    = SYNC_PATTERN[2:0];
        end else begin
          pre_nxt   = pre_cnt + 2'd1;
          out_nxt   = SYNC_PATTERN[PRE_LAST - pre_nxt];
          valid_nxt = 1'b1;
        end
      end
      DATA: begin
        if (hist == STUFF_TRIGGER) begin
          state_nxt = STUFF;
          out_nxt   = 1'b0;
          valid_nxt = 1'b1;
          hist_nxt  = 3'b000;
          done_nxt  = (bit_cnt == LAST_CNT);
        end else if (bit_cnt == LAST_CNT) begin
          state_nxt = IDLE;
        end else begin
          emit_payload = 1'b1;
        end
      end
      STUFF: begin
        if (bit_cnt == LAST_CNT) begin
          state_nxt = IDLE;
        end else begin
          emit_payload = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The last payload bit only ends the frame if it does not need a trailing stuff.
    if (emit_payload) begin
      state_nxt = DATA;
      hist_nxt  = {hist_base[1:0], shreg[DATA_W-1]};
      out_nxt   = shreg[DATA_W-1];
      valid_nxt = 1'b1;
      shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
      cnt_nxt   = bit_cnt + CNT_W'(1);
      done_nxt  = (cnt_nxt == LAST_CNT) && (hist_nxt != STUFF_TRIGGER);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      pre_cnt    <= 2'd0;
      hist       <= 3'b000;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= cnt_nxt;
      pre_cnt    <= pre_nxt;
      hist       <= hist_nxt;
      out        <= out_nxt;
      out_valid  <= valid_nxt;
      frame_done <= done_nxt;
    end
  end

  assign in_ready = (state == IDLE);

endmodule
